// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the MIPS memory responder: FSM states,
// default fetch filler word and the big-endian byte-lane mapping.
package mips_mem_responder_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  localparam int NUM_LANES = 4;

  // Lane i covers bits [LANE_LSB[i] +: 8]; lane 3 is byte offset 0 (big-endian).
  localparam int LANE_LSB [NUM_LANES] = '{0, 8, 16, 24};

endpackage

// File: rtl/mem_responder_ram.sv
// Word-addressed 32-bit RAM: port A read/byte-write (data or preload), port B
// read-only (fetch). Both ports are read-before-write with registered outputs.
module mem_responder_ram
  import mips_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic                  a_rd,
  input  logic [3:0]            a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  output logic [31:0]           a_rdata,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [31:0]           b_rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_rd) begin
        a_rdata <= mem[a_addr];
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (a_we[i]) begin
          mem[a_addr][LANE_LSB[i] +: 8] <= a_wdata[LANE_LSB[i] +: 8];
        end
      end
    end
  end

  // Separate read process sees the pre-edge array, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the pipelined MIPS core: host preload, then
// instruction fetch and data load/store against one on-chip RAM.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = DEFAULT_NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  cpu_en,
  input  logic [31:0]           pc,
  output logic [31:0]           instr,
  input  logic                  mem_read_en,
  input  logic [3:0]            mem_write_en,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_write_data,
  output logic [31:0]           mem_read_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  addr_fault
);

  localparam int CW = ADDR_WIDTH + 1;

  state_t state, next_state;

  logic                  load_accept;
  logic                  load_addr_ok;
  logic                  pc_ok;
  logic                  data_in_range;
  logic                  load_fault;
  logic                  fetch_fault;
  logic                  data_fault;
  logic                  instr_from_ram;
  logic                  rdata_from_ram;

  logic                  ram_a_en;
  logic                  ram_a_rd;
  logic [3:0]            ram_a_we;
  logic [ADDR_WIDTH-1:0] ram_a_addr;
  logic [31:0]           ram_a_wdata;
  logic [31:0]           ram_a_rdata;
  logic [31:0]           ram_b_rdata;

  // Byte-offset bits of the data address never pick a lane; the enables do.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  function automatic logic in_range(input logic [31:0] addr);
    return addr[31:ADDR_WIDTH+2] == '0;
  endfunction

  assign load_addr_ok  = in_range(load_addr) && (load_addr[1:0] == 2'b00);
  assign pc_ok         = in_range(pc) && (pc[1:0] == 2'b00);
  assign data_in_range = in_range(mem_addr);
  assign load_accept   = load_valid && load_ready;

  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    cpu_en     = 1'b0;
    case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && load_last) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_en = en;
      end
      default: next_state = ST_LOAD;
    endcase
  end

  // Port A belongs to the preload path in LOAD and to the CPU data path in RUN.
  always_comb begin
    ram_a_en    = 1'b0;
    ram_a_rd    = 1'b0;
    ram_a_we    = 4'h0;
    ram_a_addr  = mem_addr[ADDR_WIDTH+1:2];
    ram_a_wdata = mem_write_data;
    if (state == ST_LOAD) begin
      ram_a_en    = load_accept && load_addr_ok;
      ram_a_we    = 4'hF;
      ram_a_addr  = load_addr[ADDR_WIDTH+1:2];
      ram_a_wdata = load_data;
    end else begin
      ram_a_en = cpu_en && data_in_range;
      ram_a_rd = mem_read_en;
      ram_a_we = mem_write_en;
    end
  end

  assign load_fault  = load_accept && !load_addr_ok;
  assign fetch_fault = cpu_en && !pc_ok;
  assign data_fault  = cpu_en && !data_in_range && (mem_read_en || (mem_write_en != 4'h0));

  mem_responder_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .a_en    (ram_a_en),
    .a_rd    (ram_a_rd),
    .a_we    (ram_a_we),
    .a_addr  (ram_a_addr),
    .a_wdata (ram_a_wdata),
    .a_rdata (ram_a_rdata),
    .b_en    (cpu_en && pc_ok),
    .b_addr  (pc[ADDR_WIDTH+1:2]),
    .b_rdata (ram_b_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count <= '0;
      addr_fault <= 1'b0;
    end else begin
      if (load_accept && (load_count != {CW{1'b1}})) begin
        load_count <= load_count + CW'(1);
      end
      if (load_fault || fetch_fault || data_fault) begin
        addr_fault <= 1'b1;
      end
    end
  end

  // The RAM output registers are not reset, so these flags select the filler
  // value after reset and after a faulted access until a good access lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_from_ram <= 1'b0;
      rdata_from_ram <= 1'b0;
    end else begin
      if (cpu_en) begin
        instr_from_ram <= pc_ok;
      end
      if (cpu_en && mem_read_en) begin
        rdata_from_ram <= data_in_range;
      end
    end
  end

  assign instr         = instr_from_ram ? ram_b_rdata : NOP_WORD;
  assign mem_read_data = rdata_from_ram ? ram_a_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed vector table, hand-written
// preload/fault/reset sequences and a randomized run against a memory model.
module tb_mips_mem_responder;

  localparam int          AW  = 10;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] WORD_A = 32'hA5A5_0010;
  localparam logic [31:0] WORD_B = 32'h5A5A_0011;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cpu_en;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          mem_read_en;
  logic [3:0]    mem_write_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic          load_last;
  logic [AW:0]   load_count;
  logic          addr_fault;

  always #5 clk = ~clk;

  mips_mem_responder #(
    .ADDR_WIDTH(AW),
    .NOP_WORD  (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .cpu_en         (cpu_en),
    .pc             (pc),
    .instr          (instr),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_count     (load_count),
    .addr_fault     (addr_fault)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: memory image plus the values the outputs should show.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic        ref_run;
  logic [31:0] exp_instr;
  logic [31:0] exp_rdata;
  logic        exp_fault;
  int          exp_count;

  typedef struct {
    string       name;
    logic        en;
    logic [31:0] pc;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic bit addr_ok(input logic [31:0] a);
    return a < (32'd1 << (AW + 2));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, " instr"}, instr, exp_instr);
    checkOutput({tag, " mem_read_data"}, mem_read_data, exp_rdata);
    checkOutput({tag, " addr_fault"}, 32'(addr_fault), 32'(exp_fault));
  endtask

  // One CPU-side cycle: drive, predict from the model, clock, settle.
  task automatic applyStimulus(input logic e, input logic [31:0] p, input logic r,
                               input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word;
    en = e; pc = p; mem_read_en = r; mem_write_en = w; mem_addr = a; mem_write_data = d;
    if (ref_run && e) begin
      if (addr_ok(p) && (p % 4 == 0)) begin
        exp_instr = ref_mem[word_of(p)];
      end else begin
        exp_instr = NOP;
        exp_fault = 1'b1;
      end
      if (addr_ok(a)) begin
        if (r) exp_rdata = ref_mem[word_of(a)];
        word = ref_mem[word_of(a)];
        for (int i = 0; i < 4; i++) begin
          if (w[i]) word[8*i +: 8] = d[8*i +: 8];
        end
        ref_mem[word_of(a)] = word;
      end else begin
        if (r) exp_rdata = 32'h0;
        if (r || (w != 4'h0)) exp_fault = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic loadBeat(input logic [31:0] a, input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_addr = a; load_data = d; load_last = last;
    if (addr_ok(a) && (a % 4 == 0)) ref_mem[word_of(a)] = d;
    else exp_fault = 1'b1;
    if (exp_count < (1 << (AW + 1)) - 1) exp_count++;
    @(posedge clk);
    #1;
    if (last) ref_run = 1'b1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  // Asynchronous reset: outputs are checked before any clock edge arrives.
  task automatic doReset(input string tag);
    rst = 1'b1;
    #2;
    ref_run = 1'b0; exp_instr = NOP; exp_rdata = 32'h0; exp_fault = 1'b0; exp_count = 0;
    compareModel(tag);
    checkOutput({tag, " load_count"}, 32'(load_count), 32'd0);
    checkOutput({tag, " load_ready"}, 32'(load_ready), 32'd1);
    checkOutput({tag, " cpu_en"}, 32'(cpu_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic addVec(input string n, input logic e, input logic [31:0] p, input logic r,
                        input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ei, input logic [31:0] er);
    vec_t v;
    v.name = n; v.en = e; v.pc = p; v.rd = r; v.we = w; v.addr = a; v.wdata = d;
    v.exp_instr = ei; v.exp_rdata = er;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; pc = 32'h0; mem_read_en = 1'b0; mem_write_en = 4'h0;
    mem_addr = 32'h0; mem_write_data = 32'h0;
    load_valid = 1'b0; load_addr = 32'h0; load_data = 32'h0; load_last = 1'b0;
    ref_run = 1'b0; exp_instr = NOP; exp_rdata = 32'h0; exp_fault = 1'b0; exp_count = 0;
    #1;
    doReset("reset");

    // Partial preload interrupted by reset; the two words must survive.
    loadBeat(32'h28, WORD_A, 1'b0);
    loadBeat(32'h2C, WORD_B, 1'b0);
    checkOutput("partial load_count", 32'(load_count), 32'd2);
    doReset("mid-preload reset");

    // Full preload with hostile CPU-side inputs that LOAD must ignore.
    en = 1'b1; pc = 32'h2; mem_read_en = 1'b1; mem_write_en = 4'hF;
    mem_addr = 32'h0001_0000; mem_write_data = 32'hFFFF_FFFF;
    loadBeat(32'h100, 32'h1122_3344, 1'b0);
    for (int w = 3; w < 64; w++) begin
      if (w != 10 && w != 11) loadBeat(32'(w * 4), $urandom, 1'b0);
    end
    loadBeat(32'h0, 32'h2402_0005, 1'b0);
    loadBeat(32'h4, 32'h2403_0007, 1'b0);
    checkOutput("cpu_en before last beat", 32'(cpu_en), 32'd0);
    loadBeat(32'h8, 32'h0043_2021, 1'b1);
    checkOutput("preload load_count", 32'(load_count), 32'(exp_count));
    checkOutput("cpu_en after last beat", 32'(cpu_en), 32'd1);
    checkOutput("load_ready in RUN", 32'(load_ready), 32'd0);
    compareModel("LOAD ignores CPU port");

    addVec("fetch pc4",        1, 32'h04, 0, 4'h0, 32'h000, 32'h0,         32'h2403_0007, 32'h0);
    addVec("hold en0",         0, 32'h08, 1, 4'hF, 32'h100, 32'h0,         32'h2403_0007, 32'h0);
    addVec("fetch+read",       1, 32'h00, 1, 4'h0, 32'h100, 32'h0,         32'h2402_0005, 32'h1122_3344);
    addVec("byte store",       1, 32'h08, 0, 4'b0010, 32'h103, 32'hABAB_ABAB, 32'h0043_2021, 32'h1122_3344);
    addVec("read byte store",  1, 32'h08, 1, 4'h0, 32'h100, 32'h0,         32'h0043_2021, 32'h1122_AB44);
    addVec("half store rbw",   1, 32'h08, 1, 4'b1100, 32'h100, 32'hBEEF_BEEF, 32'h0043_2021, 32'h1122_AB44);
    addVec("read half store",  1, 32'h08, 1, 4'h0, 32'h100, 32'h0,         32'h0043_2021, 32'hBEEF_AB44);
    addVec("retained words",   1, 32'h2C, 1, 4'h0, 32'h028, 32'h0,         WORD_B,        WORD_A);
    addVec("fetch collision",  1, 32'h28, 0, 4'hF, 32'h028, 32'hDEAD_BEEF, WORD_A,        WORD_A);
    addVec("load after store", 1, 32'h28, 1, 4'h0, 32'h028, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].pc, vecs[i].rd, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput({vecs[i].name, " instr"}, instr, vecs[i].exp_instr);
      checkOutput({vecs[i].name, " mem_read_data"}, mem_read_data, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, " addr_fault"}, 32'(addr_fault), 32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 7) != 0),
                    32'($urandom_range(0, 64) * 4),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                    32'($urandom_range(0, 64) * 4 + $urandom_range(0, 3)),
                    $urandom);
      compareModel("random");
    end

    applyStimulus(1, 32'h0, 1, 4'h0, 32'h0001_0000, 32'h0);
    checkOutput("oob load data", mem_read_data, 32'h0);
    checkOutput("oob load fault", 32'(addr_fault), 32'd1);
    applyStimulus(1, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("fault sticky", 32'(addr_fault), 32'd1);
    applyStimulus(1, 32'h0, 0, 4'hF, 32'h0001_0000, 32'hCAFE_F00D);
    applyStimulus(1, 32'h4, 1, 4'h0, 32'h0, 32'h0);
    compareModel("oob store suppressed");
    applyStimulus(1, 32'h2, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("misaligned pc instr", instr, NOP);
    applyStimulus(1, 32'h0004_0000, 0, 4'h0, 32'h0, 32'h0);
    compareModel("oob pc");

    doReset("reset in RUN");

    // Bad preload beats are counted but not written, and raise the fault.
    loadBeat(32'h102, 32'h7777_7777, 1'b0);
    checkOutput("misaligned beat fault", 32'(addr_fault), 32'd1);
    loadBeat(32'h0001_0100, 32'h8888_8888, 1'b1);
    checkOutput("bad beats counted", 32'(load_count), 32'd2);
    applyStimulus(1, 32'h100, 1, 4'h0, 32'h100, 32'h0);
    compareModel("bad beats not written");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
